// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared encodings, ALU operation enum and control bundle for
//               the five-stage MIPS-subset core.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_BNE   = 6'h05;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_SLTI  = 6'h0A;
    localparam logic [5:0] c_OP_ANDI  = 6'h0C;
    localparam logic [5:0] c_OP_ORI   = 6'h0D;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;

    localparam logic [5:0] c_FN_SLL   = 6'h00;
    localparam logic [5:0] c_FN_SRL   = 6'h02;
    localparam logic [5:0] c_FN_ADD   = 6'h20;
    localparam logic [5:0] c_FN_SUB   = 6'h22;
    localparam logic [5:0] c_FN_AND   = 6'h24;
    localparam logic [5:0] c_FN_OR    = 6'h25;
    localparam logic [5:0] c_FN_SLT   = 6'h2A;

    localparam logic [31:0] c_NOP = 32'h0000_0000;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_SLT  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_NONE = 4'd15
    } alu_op_e;

    typedef struct packed {
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    mem_to_reg;
        logic    alu_src;
        alu_op_e opSel;
    } ctrl_t;

    localparam ctrl_t c_CTRL_NONE = '0;

    // Shifts take their operand from the rt path (b), amount from shamt.
    function automatic logic [31:0] alu_compute(
        input alu_op_e     op,
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [4:0]  shamt
    );
        logic [31:0] res;
        case (op)
            ALU_ADD: res = a + b;
            ALU_SUB: res = a - b;
            ALU_AND: res = a & b;
            ALU_OR:  res = a | b;
            ALU_SLT: res = {31'b0, ($signed(a) < $signed(b))};
            ALU_SLL: res = b << shamt;
            ALU_SRL: res = b >> shamt;
            default: res = '0;
        endcase
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
// Module      : reg_file
// Description : 32x32 register file, two async read ports, one write port,
//               r0 hardwired to zero, same-cycle write bypass to the reads.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  i_raddr1,
    input  logic [4:0]  i_raddr2,
    output logic [31:0] o_rdata1,
    output logic [31:0] o_rdata2,
    input  logic        i_we,
    input  logic [4:0]  i_waddr,
    input  logic [31:0] i_wdata
);

    logic [31:0] registers [0:31];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                registers[i] <= '0;
            end
        end else if (i_we && (i_waddr != 5'd0)) begin
            registers[i_waddr] <= i_wdata;
        end
    end

    always_comb begin
        o_rdata1 = registers[i_raddr1];
        o_rdata2 = registers[i_raddr2];
        if (i_raddr1 == 5'd0) begin
            o_rdata1 = '0;
        end else if (i_we && (i_waddr == i_raddr1)) begin
            o_rdata1 = i_wdata;
        end
        if (i_raddr2 == 5'd0) begin
            o_rdata2 = '0;
        end else if (i_we && (i_waddr == i_raddr2)) begin
            o_rdata2 = i_wdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipelined_processor.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_processor
// Description : Five-stage in-order MIPS-subset core with EX forwarding,
//               load-use stall and ID-stage branch/jump resolution.
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_processor
    import cpu_pkg::*;
#(
    parameter int    PC_W      = 6,
    parameter int    DADDR_W   = 6,
    parameter string IMEM_FILE = "imem.hex"
) (
    input  logic            clk,
    input  logic            rst,
    output logic [PC_W-1:0] PC
);

    localparam int IMEM_DEPTH = 1 << PC_W;
    localparam int DMEM_DEPTH = 1 << DADDR_W;

    logic [31:0] imem  [0:IMEM_DEPTH-1];
    logic [31:0] r_dmem [0:DMEM_DEPTH-1];

    // ROM image; unloaded words stay NOP.
    initial begin
        for (int i = 0; i < IMEM_DEPTH; i++) begin
            imem[i] = c_NOP;
        end
    end

    // ---------------- IF ----------------
    logic [PC_W-1:0] PCout;
    logic [31:0]     instruction;
    logic [31:0]     instruction_IFID;
    logic [PC_W-1:0] r_pc1_ifid;

    assign instruction = imem[PCout];
    assign PC          = PCout;

    // ---------------- ID ----------------
    logic [5:0]  w_op, w_funct;
    logic [4:0]  w_rs, w_rt, w_rd, w_shamt;
    logic [15:0] w_imm16;
    logic [31:0] w_imm_ext;
    logic [4:0]  w_dst;
    ctrl_t       w_ctrl;
    logic        w_uses_rs, w_uses_rt, w_is_branch, w_is_bne, w_is_jump;
    logic [31:0] w_rd1, w_rd2, w_br_a, w_br_b;
    logic        w_take, w_load_use, w_br_hazard, w_stall, w_flush;
    logic [PC_W-1:0] w_pc_target;

    // ---------------- EX / MEM / WB ----------------
    ctrl_t       r_idex_ctrl;
    logic [4:0]  r_idex_rs, r_idex_rt, r_idex_dst, r_idex_shamt;
    logic [31:0] r_idex_rd1, r_idex_rd2, r_idex_imm;
    logic [31:0] w_fwd_a, w_fwd_b, w_alu_b, ALUResult;

    logic        r_exmem_reg_write, r_exmem_mem_read, r_exmem_mem_write, r_exmem_mem_to_reg;
    logic [4:0]  r_exmem_dst;
    logic [31:0] r_exmem_alu, r_exmem_store;
    logic [DADDR_W-1:0] w_daddr;

    logic        r_memwb_reg_write, r_memwb_mem_to_reg;
    logic [4:0]  r_memwb_dst;
    logic [31:0] r_memwb_alu, r_memwb_mdata, writeData;

    assign w_op    = instruction_IFID[31:26];
    assign w_rs    = instruction_IFID[25:21];
    assign w_rt    = instruction_IFID[20:16];
    assign w_rd    = instruction_IFID[15:11];
    assign w_shamt = instruction_IFID[10:6];
    assign w_funct = instruction_IFID[5:0];
    assign w_imm16 = instruction_IFID[15:0];

    always_comb begin
        w_ctrl      = c_CTRL_NONE;
        w_dst       = '0;
        w_uses_rs   = 1'b0;
        w_uses_rt   = 1'b0;
        w_is_branch = 1'b0;
        w_is_bne    = 1'b0;
        w_is_jump   = 1'b0;
        w_imm_ext   = {{16{w_imm16[15]}}, w_imm16};
        case (w_op)
            c_OP_RTYPE: begin
                w_uses_rs        = 1'b1;
                w_uses_rt        = 1'b1;
                w_dst            = w_rd;
                w_ctrl.reg_write = 1'b1;
                case (w_funct)
                    c_FN_ADD: w_ctrl.opSel = ALU_ADD;
                    c_FN_SUB: w_ctrl.opSel = ALU_SUB;
                    c_FN_AND: w_ctrl.opSel = ALU_AND;
                    c_FN_OR:  w_ctrl.opSel = ALU_OR;
                    c_FN_SLT: w_ctrl.opSel = ALU_SLT;
                    c_FN_SLL: w_ctrl.opSel = ALU_SLL;
                    c_FN_SRL: w_ctrl.opSel = ALU_SRL;
                    default:  w_ctrl.reg_write = 1'b0;
                endcase
            end
            c_OP_ADDI, c_OP_SLTI, c_OP_ANDI, c_OP_ORI: begin
                w_uses_rs        = 1'b1;
                w_dst            = w_rt;
                w_ctrl.reg_write = 1'b1;
                w_ctrl.alu_src   = 1'b1;
                case (w_op)
                    c_OP_SLTI: w_ctrl.opSel = ALU_SLT;
                    c_OP_ANDI: w_ctrl.opSel = ALU_AND;
                    c_OP_ORI:  w_ctrl.opSel = ALU_OR;
                    default:   w_ctrl.opSel = ALU_ADD;
                endcase
                if (w_op == c_OP_ANDI || w_op == c_OP_ORI) begin
                    w_imm_ext = {16'h0000, w_imm16};
                end
            end
            c_OP_LW: begin
                w_uses_rs         = 1'b1;
                w_dst             = w_rt;
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.mem_read   = 1'b1;
                w_ctrl.mem_to_reg = 1'b1;
                w_ctrl.alu_src    = 1'b1;
            end
            c_OP_SW: begin
                w_uses_rs        = 1'b1;
                w_uses_rt        = 1'b1;
                w_ctrl.mem_write = 1'b1;
                w_ctrl.alu_src   = 1'b1;
            end
            c_OP_BEQ, c_OP_BNE: begin
                w_uses_rs   = 1'b1;
                w_uses_rt   = 1'b1;
                w_is_branch = 1'b1;
                w_is_bne    = (w_op == c_OP_BNE);
            end
            c_OP_J: w_is_jump = 1'b1;
            default: ;
        endcase
        // A write to r0 is architecturally dead; dropping it keeps NOPs out of forwarding.
        if (w_dst == 5'd0) begin
            w_ctrl.reg_write = 1'b0;
        end
    end

    reg_file RF (
        .clk      (clk),
        .rst      (rst),
        .i_raddr1 (w_rs),
        .i_raddr2 (w_rt),
        .o_rdata1 (w_rd1),
        .o_rdata2 (w_rd2),
        .i_we     (r_memwb_reg_write),
        .i_waddr  (r_memwb_dst),
        .i_wdata  (writeData)
    );

    // Branch operands: EX/MEM ALU result bypass; MEM/WB is covered by the RF bypass.
    assign w_br_a = (r_exmem_reg_write && (r_exmem_dst != 5'd0) && (r_exmem_dst == w_rs))
                    ? r_exmem_alu : w_rd1;
    assign w_br_b = (r_exmem_reg_write && (r_exmem_dst != 5'd0) && (r_exmem_dst == w_rt))
                    ? r_exmem_alu : w_rd2;
    assign w_take = w_is_branch && ((w_br_a == w_br_b) ^ w_is_bne);

    assign w_load_use  = r_idex_ctrl.mem_read &&
                         ((w_uses_rs && (r_idex_rt == w_rs)) || (w_uses_rt && (r_idex_rt == w_rt)));
    assign w_br_hazard = w_is_branch && (
                         (r_idex_ctrl.reg_write && (r_idex_dst != 5'd0) &&
                          ((r_idex_dst == w_rs) || (r_idex_dst == w_rt))) ||
                         (r_exmem_mem_read && (r_exmem_dst != 5'd0) &&
                          ((r_exmem_dst == w_rs) || (r_exmem_dst == w_rt))));
    assign w_stall     = w_load_use || w_br_hazard;
    assign w_flush     = !w_stall && (w_take || w_is_jump);
    assign w_pc_target = w_is_jump ? instruction_IFID[PC_W-1:0]
                                   : r_pc1_ifid + w_imm16[PC_W-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            PCout            <= '0;
            instruction_IFID <= c_NOP;
            r_pc1_ifid       <= '0;
        end else if (w_stall) begin
            PCout            <= PCout;
            instruction_IFID <= instruction_IFID;
            r_pc1_ifid       <= r_pc1_ifid;
        end else if (w_flush) begin
            PCout            <= w_pc_target;
            instruction_IFID <= c_NOP;
            r_pc1_ifid       <= '0;
        end else begin
            PCout            <= PCout + PC_W'(1);
            instruction_IFID <= instruction;
            r_pc1_ifid       <= PCout + PC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst || !rst) begin
            r_idex_ctrl  <= c_CTRL_NONE;
            r_idex_rs    <= '0;
            r_idex_rt    <= '0;
            r_idex_dst   <= '0;
            r_idex_shamt <= '0;
            r_idex_rd1   <= '0;
            r_idex_rd2   <= '0;
            r_idex_imm   <= '0;
        end else if (w_stall) begin
            r_idex_ctrl  <= c_CTRL_NONE;
            r_idex_rs    <= '0;
            r_idex_rt    <= '0;
            r_idex_dst   <= '0;
            r_idex_shamt <= '0;
            r_idex_rd1   <= '0;
            r_idex_rd2   <= '0;
            r_idex_imm   <= '0;
        end else begin
            r_idex_ctrl  <= w_ctrl;
            r_idex_rs    <= w_rs;
            r_idex_rt    <= w_rt;
            r_idex_dst   <= w_dst;
            r_idex_shamt <= w_shamt;
            r_idex_rd1   <= w_rd1;
            r_idex_rd2   <= w_rd2;
            r_idex_imm   <= w_imm_ext;
        end
    end

    // EX/MEM has priority over MEM/WB; the forwarded rt value also feeds sw data.
    always_comb begin
        w_fwd_a = r_idex_rd1;
        w_fwd_b = r_idex_rd2;
        if (r_exmem_reg_write && (r_exmem_dst != 5'd0) && (r_exmem_dst == r_idex_rs)) begin
            w_fwd_a = r_exmem_alu;
        end else if (r_memwb_reg_write && (r_memwb_dst != 5'd0) && (r_memwb_dst == r_idex_rs)) begin
            w_fwd_a = writeData;
        end
        if (r_exmem_reg_write && (r_exmem_dst != 5'd0) && (r_exmem_dst == r_idex_rt)) begin
            w_fwd_b = r_exmem_alu;
        end else if (r_memwb_reg_write && (r_memwb_dst != 5'd0) && (r_memwb_dst == r_idex_rt)) begin
            w_fwd_b = writeData;
        end
    end

    assign w_alu_b   = r_idex_ctrl.alu_src ? r_idex_imm : w_fwd_b;
    assign ALUResult = alu_compute(r_idex_ctrl.opSel, w_fwd_a, w_alu_b, r_idex_shamt);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_exmem_reg_write  <= 1'b0;
            r_exmem_mem_read   <= 1'b0;
            r_exmem_mem_write  <= 1'b0;
            r_exmem_mem_to_reg <= 1'b0;
            r_exmem_dst        <= '0;
            r_exmem_alu        <= '0;
            r_exmem_store      <= '0;
        end else begin
            r_exmem_reg_write  <= r_idex_ctrl.reg_write;
            r_exmem_mem_read   <= r_idex_ctrl.mem_read;
            r_exmem_mem_write  <= r_idex_ctrl.mem_write;
            r_exmem_mem_to_reg <= r_idex_ctrl.mem_to_reg;
            r_exmem_dst        <= r_idex_dst;
            r_exmem_alu        <= ALUResult;
            r_exmem_store      <= w_fwd_b;
        end
    end

    assign w_daddr = r_exmem_alu[DADDR_W-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DMEM_DEPTH; i++) begin
                r_dmem[i] <= '0;
            end
        end else if (r_exmem_mem_write) begin
            r_dmem[w_daddr] <= r_exmem_store;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_memwb_reg_write  <= 1'b0;
            r_memwb_mem_to_reg <= 1'b0;
            r_memwb_dst        <= '0;
            r_memwb_alu        <= '0;
            r_memwb_mdata      <= '0;
        end else begin
            r_memwb_reg_write  <= r_exmem_reg_write;
            r_memwb_mem_to_reg <= r_exmem_mem_to_reg;
            r_memwb_dst        <= r_exmem_dst;
            r_memwb_alu        <= r_exmem_alu;
            r_memwb_mdata      <= r_dmem[w_daddr];
        end
    end

    assign writeData = r_memwb_mem_to_reg ? r_memwb_mdata : r_memwb_alu;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_processor.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_processor
// Description : Directed program with cycle-exact PC trace, final register
//               table, latency and asynchronous mid-run reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_processor;

    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] val;
    } reg_vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] pc;

    int total = 0;
    int bad   = 0;

    pipelined_processor #(
        .PC_W      (6),
        .DADDR_W   (6),
        .IMEM_FILE ("")
    ) dut (
        .clk (clk),
        .rst (rst),
        .PC  (pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h want %08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rins(input logic [5:0] fn, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd,
                                         input logic [4:0] sh);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] iins(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    logic [31:0] prog   [0:63];
    logic [5:0]  pc_tbl [0:32];
    reg_vec_t    reg_tbl [0:21];

    initial begin
        rst = 1'b0;
        for (int i = 0; i < 64; i++) prog[i] = 32'h0;
        prog[0]  = iins(6'h08, 0, 1, 16'd5);         // addi r1,r0,5
        prog[1]  = iins(6'h08, 0, 2, 16'd7);         // addi r2,r0,7
        prog[2]  = rins(6'h20, 1, 2, 3, 0);          // add r3,r1,r2
        prog[3]  = iins(6'h2B, 0, 3, 16'd0);         // sw r3,0(r0)
        prog[4]  = iins(6'h23, 0, 4, 16'd0);         // lw r4,0(r0)
        prog[5]  = rins(6'h20, 4, 4, 5, 0);          // add r5,r4,r4
        prog[6]  = iins(6'h08, 0, 6, 16'd1);         // addi r6,r0,1
        prog[7]  = iins(6'h04, 6, 6, 16'd2);         // beq r6,r6,+2
        prog[8]  = iins(6'h08, 0, 9, 16'h0055);      // skipped
        prog[9]  = iins(6'h08, 0, 10, 16'h0066);     // skipped
        prog[10] = iins(6'h05, 0, 0, 16'd4);         // bne r0,r0,+4
        prog[11] = iins(6'h08, 0, 0, 16'd9);         // addi r0,r0,9
        prog[12] = iins(6'h0A, 0, 7, 16'hFFFF);      // slti r7,r0,-1
        prog[13] = rins(6'h22, 0, 1, 8, 0);          // sub r8,r0,r1
        prog[14] = rins(6'h24, 3, 2, 11, 0);         // and
        prog[15] = rins(6'h25, 3, 2, 12, 0);         // or
        prog[16] = rins(6'h2A, 8, 1, 13, 0);         // slt r13,r8,r1
        prog[17] = rins(6'h00, 0, 2, 14, 5'd4);      // sll r14,r2,4
        prog[18] = rins(6'h02, 0, 8, 15, 5'd28);     // srl r15,r8,28
        prog[19] = iins(6'h0C, 8, 16, 16'hFF00);     // andi
        prog[20] = iins(6'h0D, 0, 17, 16'h8001);     // ori
        prog[21] = iins(6'h08, 0, 18, 16'hFFFF);     // addi r18,r0,-1
        prog[22] = iins(6'h23, 0, 19, 16'd0);        // lw r19,0(r0)
        prog[23] = iins(6'h04, 19, 3, 16'd1);        // beq r19,r3,+1 (two stalls)
        prog[24] = iins(6'h08, 0, 20, 16'h0077);     // skipped
        prog[25] = {6'h02, 26'h000003F};             // j 0x3F
        prog[63] = iins(6'h08, 0, 21, 16'd3);        // addi r21,r0,3

        pc_tbl = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd6, 6'd7, 6'd8, 6'd8,
                   6'd10, 6'd11, 6'd12, 6'd13, 6'd14, 6'd15, 6'd16, 6'd17, 6'd18, 6'd19,
                   6'd20, 6'd21, 6'd22, 6'd23, 6'd24, 6'd24, 6'd24, 6'd25, 6'd26, 6'd63,
                   6'd0, 6'd1};

        reg_tbl[0]  = '{5'd0,  32'h0000_0000};
        reg_tbl[1]  = '{5'd1,  32'h0000_0005};
        reg_tbl[2]  = '{5'd2,  32'h0000_0007};
        reg_tbl[3]  = '{5'd3,  32'h0000_000C};
        reg_tbl[4]  = '{5'd4,  32'h0000_000C};
        reg_tbl[5]  = '{5'd5,  32'h0000_0018};
        reg_tbl[6]  = '{5'd6,  32'h0000_0001};
        reg_tbl[7]  = '{5'd7,  32'h0000_0000};
        reg_tbl[8]  = '{5'd8,  32'hFFFF_FFFB};
        reg_tbl[9]  = '{5'd9,  32'h0000_0000};
        reg_tbl[10] = '{5'd10, 32'h0000_0000};
        reg_tbl[11] = '{5'd11, 32'h0000_0004};
        reg_tbl[12] = '{5'd12, 32'h0000_000F};
        reg_tbl[13] = '{5'd13, 32'h0000_0001};
        reg_tbl[14] = '{5'd14, 32'h0000_0070};
        reg_tbl[15] = '{5'd15, 32'h0000_000F};
        reg_tbl[16] = '{5'd16, 32'h0000_FF00};
        reg_tbl[17] = '{5'd17, 32'h0000_8001};
        reg_tbl[18] = '{5'd18, 32'hFFFF_FFFF};
        reg_tbl[19] = '{5'd19, 32'h0000_000C};
        reg_tbl[20] = '{5'd20, 32'h0000_0000};
        reg_tbl[21] = '{5'd21, 32'h0000_0003};

        #1;
        for (int i = 0; i < 64; i++) dut.imem[i] = prog[i];

        // Held in reset across one rising edge.
        @(negedge clk);
        check("reset_pc", {26'h0, pc}, 32'h0);
        check("reset_r1", dut.RF.registers[1], 32'h0);
        rst = 1'b1;
        #1;

        for (int t = 0; t <= 40; t++) begin
            if (t > 0) @(negedge clk);
            if (t <= 32) check($sformatf("pc_t%0d", t), {26'h0, pc}, {26'h0, pc_tbl[t]});
            if (t == 4) check("r1_before_wb", dut.RF.registers[1], 32'h0);
            if (t == 5) check("r1_after_wb", dut.RF.registers[1], 32'h5);
        end

        for (int i = 0; i < 22; i++) begin
            check($sformatf("r%0d", reg_tbl[i].idx), dut.RF.registers[reg_tbl[i].idx],
                  reg_tbl[i].val);
        end

        // Asynchronous reset mid-run, away from any clock edge.
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_pc", {26'h0, pc}, 32'h0);
        for (int i = 0; i < 32; i++) begin
            check($sformatf("async_rst_r%0d", i), dut.RF.registers[i], 32'h0);
        end
        @(negedge clk);
        check("rst_hold_pc", {26'h0, pc}, 32'h0);
        rst = 1'b1;
        #1;
        check("restart_pc0", {26'h0, pc}, 32'h0);
        for (int t = 1; t <= 8; t++) begin
            @(negedge clk);
            if (t <= 3) check($sformatf("restart_pc%0d", t), {26'h0, pc}, t);
        end
        check("restart_r3", dut.RF.registers[3], 32'h0000_000C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
